ar_tag_allocator: RTL and testbench
===================================

AR_TAG_ALLOCATOR -- requirements
Module: ar_tag_allocator

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: AXI ARID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: ARADDR width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: ARLEN width.
REQ-004 SHALL have parameter TAG_WIDTH, default 4: tag width; NUM_TAGS = 2**TAG_WIDTH.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port in_if  axi_ar_if.slave  bundle  AR request from the upstream master; its tagid field is ignored.
REQ-008 SHALL have port out_if  axi_ar_if.master  bundle  tagged AR request to the outgoing request buffer.
REQ-009 SHALL have port rel_valid  input  1  release strobe from the response path (last beat retired).
REQ-010 SHALL have port rel_tag  input  TAG_WIDTH  tag being released.
REQ-011 SHALL have port rel_id  output  ID_WIDTH  original ARID stored for rel_tag; combinational table read.
REQ-012 SHALL have port rel_err  output  1  one-cycle pulse when a free tag is released.
REQ-013 SHALL have port outstanding  output  TAG_WIDTH+1  count of busy tags.

Function
REQ-014 SHALL keep a NUM_TAGS-bit busy vector and a NUM_TAGS x ID_WIDTH id table.
REQ-015 SHALL drive in_if.ready = (at least one tag free) AND (!out_if.valid OR out_if.ready).
REQ-016 SHALL select the lowest-index free tag from the registered busy vector on every accept.
REQ-017 SHALL, on accept, register id/addr/len/size/burst/qos unchanged into out_if, set out_if.tagid to the selected tag and out_if.valid = 1 on the next cycle; latency is exactly 1 cycle.
REQ-018 SHALL, on accept, set the tag's busy bit and write in_if.id into table[tag], both visible on the next cycle.
REQ-019 SHALL hold all out_if fields stable while out_if.valid = 1 and out_if.ready = 0.
REQ-020 SHALL clear out_if.valid after a handshake unless a new accept occurs in the same cycle; back-to-back transfers at one per cycle SHALL be sustained.
REQ-021 SHALL, on rel_valid with busy[rel_tag] = 1, clear that busy bit on the next cycle.
REQ-022 SHALL, on rel_valid with busy[rel_tag] = 0, leave state unchanged and pulse rel_err for one cycle.
REQ-023 SHALL NOT offer a released tag for allocation in the cycle of its release.
REQ-024 SHALL update outstanding by +1 for an accept, -1 for a valid release, and leave it unchanged when both occur in the same cycle.
REQ-025 SHALL deassert in_if.ready while all NUM_TAGS tags are busy; the first valid release re-enables it on the following cycle.

Reset
REQ-026 SHALL, with rst high at a clock edge, clear busy, outstanding, out_if.valid and rel_err; out_if data fields and table contents are don't-care.
REQ-027 SHALL drop any in-flight request when reset occurs mid-operation; no release is required afterwards.

Configuration
REQ-028 SHALL, with AR_TAG_ALLOCATOR_STATS_EN defined, add output stall_cnt (32 bits), counting cycles with in_if.valid = 1 AND in_if.ready = 0, saturating at all-ones and cleared by reset.
REQ-029 SHALL, without AR_TAG_ALLOCATOR_STATS_EN, have no stall_cnt port or logic.

Structure
REQ-030 SHALL define the tag type, the NUM_TAGS constant and the AR request struct (id, addr, len, size, burst, qos, tagid) in shared package rob_pkg.
REQ-031 SHALL implement tag selection as sub-module tag_free_list (busy vector, lowest-free priority encoder, alloc/release ports).

Verification
REQ-032 SHALL cover: after reset, three requests with out_if.ready = 1 -> tagids 0, 1, 2 one cycle after each accept; outstanding = 3.
REQ-033 SHALL cover: 16 accepts without release -> in_if.ready = 0 with outstanding = 16; release tag 5 -> next accept gets tagid 5.
REQ-034 SHALL cover: accept ARID 0xA on tag 2, then rel_tag = 2 -> rel_id = 0xA combinationally.
REQ-035 SHALL cover: out_if.ready = 0 for 4 cycles with a pending request -> out_if fields stable and in_if.ready = 0 throughout.
REQ-036 SHALL cover: release of an unallocated tag 7 -> one-cycle rel_err, outstanding unchanged; accept plus valid release in the same cycle -> outstanding unchanged.
REQ-037 SHALL cover: rst asserted with 4 tags busy -> outstanding = 0, out_if.valid = 0 next cycle; next request gets tagid 0.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared read-reorder types: tag type, tag count and the tagged AR request layout.
package rob_pkg;

  localparam int unsigned AR_ID_WIDTH   = 4;
  localparam int unsigned AR_ADDR_WIDTH = 32;
  localparam int unsigned AR_LEN_WIDTH  = 8;
  localparam int unsigned AR_TAG_WIDTH  = 4;
  localparam int unsigned NUM_TAGS      = 2 ** AR_TAG_WIDTH;

  typedef logic [AR_TAG_WIDTH-1:0] tag_t;

  typedef struct packed {
    logic [AR_ID_WIDTH-1:0]   id;
    logic [AR_ADDR_WIDTH-1:0] addr;
    logic [AR_LEN_WIDTH-1:0]  len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic [3:0]               qos;
    tag_t                     tagid;
  } ar_req_t;

endpackage

// File: rtl/axi_ar_if.sv
// AXI read-address channel bundle extended with a reorder tag.
interface axi_ar_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned TAG_WIDTH  = 4
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [3:0]            qos;
  logic [TAG_WIDTH-1:0]  tagid;

  modport master (output valid, id, addr, len, size, burst, qos, tagid, input ready);
  modport slave  (input valid, id, addr, len, size, burst, qos, tagid, output ready);
endinterface

// File: rtl/tag_free_list.sv
// Busy vector with lowest-free-index allocation, release and a busy-tag count.
module tag_free_list #(
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  output logic                 any_free,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic                 rel_hit,
  output logic [TAG_WIDTH:0]   count
);
  localparam int Num = 2 ** TAG_WIDTH;

  logic [Num-1:0]     busy_q, busy_d;
  logic [TAG_WIDTH:0] count_q, count_d;

  // Scan from the top so the last hit wins: lowest free index.
  always_comb begin
    alloc_tag = '0;
    any_free  = 1'b0;
    for (int i = Num - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free  = 1'b1;
        alloc_tag = TAG_WIDTH'(i);
      end
    end
  end

  assign rel_hit = rel_valid && busy_q[rel_tag];

  // Allocation reads the registered vector, so a tag freed this cycle is never reissued here.
  always_comb begin
    busy_d = busy_q;
    if (rel_hit) busy_d[rel_tag] = 1'b0;
    if (alloc)   busy_d[alloc_tag] = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    unique case ({alloc, rel_hit})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
endmodule

// File: rtl/ar_tag_allocator.sv
// Tags upstream AR requests with a free reorder tag and remembers each tag's ARID.
// Optional stall counter enabled by defining AR_TAG_ALLOCATOR_STATS_EN.
module ar_tag_allocator
  import rob_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = AR_ID_WIDTH,
  parameter int unsigned ADDR_WIDTH = AR_ADDR_WIDTH,
  parameter int unsigned LEN_WIDTH  = AR_LEN_WIDTH,
  parameter int unsigned TAG_WIDTH  = AR_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_ar_if.slave              in_if,
  axi_ar_if.master             out_if,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic [ID_WIDTH-1:0]  rel_id,
  output logic                 rel_err,
  output logic [TAG_WIDTH:0]   outstanding
`ifdef AR_TAG_ALLOCATOR_STATS_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);
  localparam int unsigned TagCount = 2 ** TAG_WIDTH;

  logic                  any_free, in_ready, accept, rel_hit;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  out_valid_q, rel_err_q;
  logic [ID_WIDTH-1:0]   out_id_q;
  logic [ADDR_WIDTH-1:0] out_addr_q;
  logic [LEN_WIDTH-1:0]  out_len_q;
  logic [2:0]            out_size_q;
  logic [1:0]            out_burst_q;
  logic [3:0]            out_qos_q;
  logic [TAG_WIDTH-1:0]  out_tag_q;
  logic [ID_WIDTH-1:0]   id_table [TagCount];

  assign in_ready    = any_free && (!out_valid_q || out_if.ready);
  assign accept      = in_if.valid && in_ready;
  assign in_if.ready = in_ready;

  tag_free_list #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .alloc     (accept),
    .alloc_tag (alloc_tag),
    .any_free  (any_free),
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .rel_hit   (rel_hit),
    .count     (outstanding)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      rel_err_q   <= 1'b0;
    end else begin
      rel_err_q <= rel_valid && !rel_hit;
      if (accept) begin
        out_valid_q <= 1'b1;
      end else if (out_if.ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Payload and id table need no reset: they are only observed behind valid/busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_id_q            <= in_if.id;
      out_addr_q          <= in_if.addr;
      out_len_q           <= in_if.len;
      out_size_q          <= in_if.size;
      out_burst_q         <= in_if.burst;
      out_qos_q           <= in_if.qos;
      out_tag_q           <= alloc_tag;
      id_table[alloc_tag] <= in_if.id;
    end
  end

  assign out_if.valid = out_valid_q;
  assign out_if.id    = out_id_q;
  assign out_if.addr  = out_addr_q;
  assign out_if.len   = out_len_q;
  assign out_if.size  = out_size_q;
  assign out_if.burst = out_burst_q;
  assign out_if.qos   = out_qos_q;
  assign out_if.tagid = out_tag_q;

  assign rel_id  = id_table[rel_tag];
  assign rel_err = rel_err_q;

`ifdef AR_TAG_ALLOCATOR_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (in_if.valid && !in_ready && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_ar_tag_allocator.sv
// Directed scenarios followed by a randomized run against a tag-pool reference model.
module tb_ar_tag_allocator;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int LW  = 8;
  localparam int TW  = 4;
  localparam int NT  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi_ar_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) in_bus ();
  axi_ar_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TAG_WIDTH(TW)) out_bus ();

  logic          rel_valid;
  logic [TW-1:0] rel_tag;
  logic [IDW-1:0] rel_id;
  logic          rel_err;
  logic [TW:0]   outstanding;
`ifdef AR_TAG_ALLOCATOR_STATS_EN
  logic [31:0]   stall_cnt;
`endif

  ar_tag_allocator #(
    .ID_WIDTH   (IDW),
    .ADDR_WIDTH (AW),
    .LEN_WIDTH  (LW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_if       (in_bus),
    .out_if      (out_bus),
    .rel_valid   (rel_valid),
    .rel_tag     (rel_tag),
    .rel_id      (rel_id),
    .rel_err     (rel_err),
    .outstanding (outstanding)
`ifdef AR_TAG_ALLOCATOR_STATS_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [IDW-1:0] id);
    in_bus.valid = 1'b1;
    in_bus.id    = id;
    in_bus.addr  = $urandom;
    in_bus.len   = 8'($urandom);
    in_bus.size  = 3'($urandom);
    in_bus.burst = 2'($urandom);
    in_bus.qos   = 4'($urandom);
    in_bus.tagid = 4'($urandom);
  endtask

  // Request payload with the tag field left zero, ready to be OR-ed with the expected tag.
  function automatic logic [63:0] pk_in();
    return 64'({in_bus.id, in_bus.addr, in_bus.len, in_bus.size, in_bus.burst, in_bus.qos, 4'h0});
  endfunction

  function automatic logic [63:0] pk_out();
    return 64'({out_bus.id, out_bus.addr, out_bus.len, out_bus.size, out_bus.burst, out_bus.qos,
                out_bus.tagid});
  endfunction

  // Reference model state
  bit             m_busy [NT];
  logic [IDW-1:0] m_tab  [NT];
  bit             e_valid, e_err;
  logic [63:0]    e_pk;
  longint         e_stall;

  function automatic int busy_count();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic int lowest_free();
    for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [63:0] exp_pk;
    int          lf;
    bit          exp_ready, acc;

    rst = 1'b1;
    in_bus.valid = 1'b0; in_bus.id = '0; in_bus.addr = '0; in_bus.len = '0;
    in_bus.size = '0; in_bus.burst = '0; in_bus.qos = '0; in_bus.tagid = '0;
    out_bus.ready = 1'b1;
    rel_valid = 1'b0;
    rel_tag = '0;
    tick();
    tick();
    chk("reset_outstanding", 64'(outstanding), 64'd0);
    chk("reset_out_valid", 64'(out_bus.valid), 64'd0);
    chk("reset_rel_err", 64'(rel_err), 64'd0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_bus.ready), 64'd1);

    // First three requests get tags 0, 1, 2 one cycle after accept
    for (int k = 0; k < 3; k++) begin
      drive_req((k == 2) ? 4'hA : 4'(k + 1));
      exp_pk = pk_in() | 64'(k);
      tick();
      chk("first3_valid", 64'(out_bus.valid), 64'd1);
      chk("first3_req", pk_out(), exp_pk);
    end
    in_bus.valid = 1'b0;
    chk("first3_outstanding", 64'(outstanding), 64'd3);
    rel_tag = 4'd2;
    #1;
    chk("rel_id_tag2", 64'(rel_id), 64'hA);
    tick();
    chk("valid_clears", 64'(out_bus.valid), 64'd0);

    // Fill the pool
    for (int k = 3; k < NT; k++) begin
      drive_req(4'(k));
      tick();
      chk("fill_tag", 64'(out_bus.tagid), 64'(k));
    end
    in_bus.valid = 1'b0;
    #1;
    chk("full_outstanding", 64'(outstanding), 64'd16);
    chk("full_in_ready", 64'(in_bus.ready), 64'd0);

    // Release tag 5: not reusable in its own cycle, allocated on the next
    rel_valid = 1'b1;
    rel_tag = 4'd5;
    drive_req(4'h5);
    #1;
    chk("release_cycle_ready", 64'(in_bus.ready), 64'd0);
    tick();
    rel_valid = 1'b0;
    #1;
    chk("after_rel_outstanding", 64'(outstanding), 64'd15);
    chk("after_rel_ready", 64'(in_bus.ready), 64'd1);
    tick();
    in_bus.valid = 1'b0;
    chk("realloc_tag5", 64'(out_bus.tagid), 64'd5);
    chk("realloc_outstanding", 64'(outstanding), 64'd16);

    // Valid release of 7, then a second release of the now-free 7
    rel_valid = 1'b1;
    rel_tag = 4'd7;
    tick();
    chk("rel7_outstanding", 64'(outstanding), 64'd15);
    chk("rel7_no_err", 64'(rel_err), 64'd0);
    tick();
    rel_valid = 1'b0;
    chk("double_rel_err", 64'(rel_err), 64'd1);
    chk("double_rel_outstanding", 64'(outstanding), 64'd15);
    tick();
    chk("rel_err_one_cycle", 64'(rel_err), 64'd0);

    // Accept and valid release in the same cycle
    drive_req(4'hC);
    exp_pk = pk_in() | 64'd7;
    rel_valid = 1'b1;
    rel_tag = 4'd0;
    tick();
    rel_valid = 1'b0;
    in_bus.valid = 1'b0;
    chk("acc_rel_outstanding", 64'(outstanding), 64'd15);
    chk("acc_rel_req", pk_out(), exp_pk);

    // Downstream backpressure for 4 cycles with a new request waiting
    out_bus.ready = 1'b0;
    drive_req(4'hD);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_in_ready", 64'(in_bus.ready), 64'd0);
      chk("bp_out_valid", 64'(out_bus.valid), 64'd1);
      chk("bp_out_stable", pk_out(), exp_pk);
      tick();
    end
    out_bus.ready = 1'b1;
    exp_pk = pk_in() | 64'd0;
    #1;
    chk("bp_release_ready", 64'(in_bus.ready), 64'd1);
    tick();
    in_bus.valid = 1'b0;
    chk("bp_next_req", pk_out(), exp_pk);

    // Reset with four tags busy and a request in flight
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_req(4'(k));
      tick();
    end
    chk("pre_rst_outstanding", 64'(outstanding), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_bus.valid = 1'b0;
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_out_valid", 64'(out_bus.valid), 64'd0);
    drive_req(4'h3);
    tick();
    in_bus.valid = 1'b0;
    chk("post_rst_tag", 64'(out_bus.tagid), 64'd0);
    chk("post_rst_outstanding", 64'(outstanding), 64'd1);

    // Randomized run against the tag-pool model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    e_valid = 1'b0;
    e_err = 1'b0;
    e_pk = '0;
    e_stall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive_req(4'($urandom));
      in_bus.valid  = ($urandom_range(0, 3) != 0);
      out_bus.ready = ($urandom_range(0, 3) != 0);
      rel_valid     = ($urandom_range(0, 2) == 0);
      rel_tag       = 4'($urandom_range(0, NT - 1));
      #1;
      lf = lowest_free();
      exp_ready = (lf >= 0) && (!e_valid || out_bus.ready);
      chk("rnd_in_ready", 64'(in_bus.ready), 64'(exp_ready));
      if (m_busy[rel_tag]) chk("rnd_rel_id", 64'(rel_id), 64'(m_tab[rel_tag]));
      acc = in_bus.valid && exp_ready;
      if (in_bus.valid && !exp_ready && e_stall < 64'hFFFF_FFFF) e_stall++;
      e_err = rel_valid && !m_busy[rel_tag];
      if (rel_valid && m_busy[rel_tag]) m_busy[rel_tag] = 1'b0;
      if (acc) begin
        m_busy[lf] = 1'b1;
        m_tab[lf]  = in_bus.id;
        e_valid    = 1'b1;
        e_pk       = pk_in() | 64'(lf);
      end else if (out_bus.ready) begin
        e_valid = 1'b0;
      end
      tick();
      chk("rnd_outstanding", 64'(outstanding), 64'(busy_count()));
      chk("rnd_out_valid", 64'(out_bus.valid), 64'(e_valid));
      if (e_valid) chk("rnd_out_req", pk_out(), e_pk);
      chk("rnd_rel_err", 64'(rel_err), 64'(e_err));
`ifdef AR_TAG_ALLOCATOR_STATS_EN
      chk("rnd_stall_cnt", 64'(stall_cnt), 64'(e_stall));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
